// File: rtl/dpe_pkg.sv
// Shared types and constants for the dot-product engine: FSM state encoding,
// address step sizes and the sign-extension helper used by the MAC.
package dpe_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ISSUE_A,
    S_WAIT_A,
    S_ISSUE_B,
    S_WAIT_B,
    S_MUL,
    S_ACC,
    S_WR_LO,
    S_WAIT_LO,
    S_WR_HI,
    S_WAIT_HI,
    S_FIN
  } dpe_state_e;

  localparam logic [31:0] WORD_BYTES = 32'd4;
  localparam logic [31:0] RES_HI_OFS = 32'd4;

  function automatic logic [63:0] sext64(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

endpackage

// File: rtl/dot_product_engine_if.sv
// Request/response bus between the dot-product engine and axi_adapter:
// single-word read and write requests, each answered by a one-cycle response pulse.
interface dot_product_engine_if;
  logic        read_req;
  logic [31:0] read_addr;
  logic [31:0] read_data;
  logic        read_data_valid;
  logic        write_req;
  logic [31:0] write_addr;
  logic [31:0] write_data;
  logic        write_done;

  modport master (
    output read_req, read_addr, write_req, write_addr, write_data,
    input  read_data, read_data_valid, write_done
  );

  modport slave (
    input  read_req, read_addr, write_req, write_addr, write_data,
    output read_data, read_data_valid, write_done
  );
endinterface

// File: rtl/dpe_mac.sv
// Registered signed 32x32 multiply followed by a 64-bit wrapping accumulate,
// kept in its own module so the multiplier maps cleanly onto DSP blocks.
module dpe_mac
  import dpe_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        mul_en,
  input  logic        acc_en,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] acc
);

  logic [63:0] prod_q, prod_d;
  logic [63:0] acc_q, acc_d;

  always_comb begin
    prod_d = prod_q;
    acc_d  = acc_q;
    // Low 64 bits of the product of sign-extended operands equal the signed product.
    if (mul_en) begin
      prod_d = sext64(a) * sext64(b);
    end
    if (clr) begin
      acc_d = '0;
    end else if (acc_en) begin
      acc_d = acc_q + prod_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prod_q <= '0;
      acc_q  <= '0;
    end else begin
      prod_q <= prod_d;
      acc_q  <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/dot_product_engine.sv
// Sequencer that fetches A[i] and B[i] one word at a time through the adapter,
// accumulates their signed products and writes the 64-bit sum back as two words.
module dot_product_engine
  import dpe_pkg::*;
#(
  parameter int LEN_W = 16,
  parameter int ACC_W = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      a_base,
  input  logic [31:0]      b_base,
  input  logic [31:0]      res_addr,
  input  logic [LEN_W-1:0] vec_len,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] result,
  dot_product_engine_if.master adp
);

  dpe_state_e       state_q, state_d;
  logic [31:0]      pa_q, pa_d;
  logic [31:0]      pb_q, pb_d;
  logic [31:0]      res_addr_q, res_addr_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [31:0]      opa_q, opa_d;
  logic [31:0]      opb_q, opb_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [ACC_W-1:0] result_q, result_d;
  logic             read_req_q, read_req_d;
  logic [31:0]      read_addr_q, read_addr_d;
  logic             write_req_q, write_req_d;
  logic [31:0]      write_addr_q, write_addr_d;
  logic [31:0]      write_data_q, write_data_d;

  logic             mac_clr, mul_en, acc_en;
  logic [63:0]      acc;

  dpe_mac u_mac (
    .clk    (clk),
    .reset  (reset),
    .clr    (mac_clr),
    .mul_en (mul_en),
    .acc_en (acc_en),
    .a      (opa_q),
    .b      (opb_q),
    .acc    (acc)
  );

  always_comb begin
    state_d      = state_q;
    pa_d         = pa_q;
    pb_d         = pb_q;
    res_addr_d   = res_addr_q;
    cnt_d        = cnt_q;
    opa_d        = opa_q;
    opb_d        = opb_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    result_d     = result_q;
    read_req_d   = 1'b0;
    read_addr_d  = read_addr_q;
    write_req_d  = 1'b0;
    write_addr_d = write_addr_q;
    write_data_d = write_data_q;
    mac_clr      = 1'b0;
    mul_en       = 1'b0;
    acc_en       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          pa_d       = a_base;
          pb_d       = b_base;
          res_addr_d = res_addr;
          cnt_d      = vec_len;
          busy_d     = 1'b1;
          mac_clr    = 1'b1;
          state_d    = (vec_len != '0) ? S_ISSUE_A : S_WR_LO;
        end
      end
      S_ISSUE_A: begin
        read_req_d  = 1'b1;
        read_addr_d = pa_q;
        state_d     = S_WAIT_A;
      end
      S_WAIT_A: begin
        if (adp.read_data_valid) begin
          opa_d   = adp.read_data;
          state_d = S_ISSUE_B;
        end
      end
      S_ISSUE_B: begin
        read_req_d  = 1'b1;
        read_addr_d = pb_q;
        state_d     = S_WAIT_B;
      end
      S_WAIT_B: begin
        if (adp.read_data_valid) begin
          opb_d   = adp.read_data;
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        mul_en  = 1'b1;
        state_d = S_ACC;
      end
      S_ACC: begin
        // The product registered in MUL is folded in here, so WR_LO sees the final sum.
        acc_en  = 1'b1;
        pa_d    = pa_q + WORD_BYTES;
        pb_d    = pb_q + WORD_BYTES;
        cnt_d   = cnt_q - LEN_W'(1);
        state_d = (cnt_q == LEN_W'(1)) ? S_WR_LO : S_ISSUE_A;
      end
      S_WR_LO: begin
        write_req_d  = 1'b1;
        write_addr_d = res_addr_q;
        write_data_d = acc[31:0];
        state_d      = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        if (adp.write_done) begin
          state_d = S_WR_HI;
        end
      end
      S_WR_HI: begin
        write_req_d  = 1'b1;
        write_addr_d = res_addr_q + RES_HI_OFS;
        write_data_d = acc[63:32];
        state_d      = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (adp.write_done) begin
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        result_d = acc;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      pa_q         <= '0;
      pb_q         <= '0;
      res_addr_q   <= '0;
      cnt_q        <= '0;
      opa_q        <= '0;
      opb_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      result_q     <= '0;
      read_req_q   <= 1'b0;
      read_addr_q  <= '0;
      write_req_q  <= 1'b0;
      write_addr_q <= '0;
      write_data_q <= '0;
    end else begin
      state_q      <= state_d;
      pa_q         <= pa_d;
      pb_q         <= pb_d;
      res_addr_q   <= res_addr_d;
      cnt_q        <= cnt_d;
      opa_q        <= opa_d;
      opb_q        <= opb_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      result_q     <= result_d;
      read_req_q   <= read_req_d;
      read_addr_q  <= read_addr_d;
      write_req_q  <= write_req_d;
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign result         = result_q;
  assign adp.read_req   = read_req_q;
  assign adp.read_addr  = read_addr_q;
  assign adp.write_req  = write_req_q;
  assign adp.write_addr = write_addr_q;
  assign adp.write_data = write_data_q;

endmodule

// File: tb/tb_dot_product_engine.sv
// Self-checking bench: memory-backed adapter stub with random latency, directed
// and randomized vector runs checked against a plain-arithmetic dot-product model.
module tb_dot_product_engine;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] a_base, b_base, res_addr;
  logic [15:0] vec_len;
  logic        busy, done;
  logic [63:0] result;

  dot_product_engine_if bus ();

  dot_product_engine #(.LEN_W(16), .ACC_W(64)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .a_base   (a_base),
    .b_base   (b_base),
    .res_addr (res_addr),
    .vec_len  (vec_len),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .adp      (bus.master)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] va[$];
  logic [31:0] vb[$];

  bit          rd_out, wr_out;
  int          rd_wait, wr_wait;
  logic [31:0] rd_addr_hold;
  int          rd_cnt, wr_cnt, done_cnt;
  int          lat_max;
  bit          spur_en;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] addr);
    if (mem.exists(addr)) return mem[addr];
    return 32'h0;
  endfunction

  function automatic logic [63:0] model_dot(input int n);
    longint acc = 0;
    for (int i = 0; i < n; i++) begin
      int a = va[i];
      int b = vb[i];
      acc += longint'(a) * longint'(b);
    end
    return acc;
  endfunction

  // Adapter stub: inputs change on the falling edge so the DUT samples them cleanly.
  always @(negedge clk) begin
    bit was_busy;
    bit responded;
    bus.read_data_valid = 1'b0;
    bus.write_done      = 1'b0;
    responded           = 1'b0;
    if (reset) begin
      rd_out = 1'b0;
      wr_out = 1'b0;
    end else begin
      was_busy = rd_out || wr_out;
      if (done) done_cnt++;
      if (rd_out) begin
        check("rd_addr_stable", 64'(bus.read_addr), 64'(rd_addr_hold));
        if (rd_wait == 0) begin
          bus.read_data_valid = 1'b1;
          bus.read_data       = mem_rd(rd_addr_hold);
          rd_out              = 1'b0;
          responded           = 1'b1;
        end else rd_wait--;
      end
      if (wr_out) begin
        if (wr_wait == 0) begin
          bus.write_done = 1'b1;
          wr_out         = 1'b0;
          responded      = 1'b1;
        end else wr_wait--;
      end
      if (bus.read_req || bus.write_req) begin
        check("req_exclusive", 64'(bus.read_req && bus.write_req), 64'd0);
        check("one_outstanding", 64'(was_busy), 64'd0);
        if (bus.read_req) begin
          rd_out       = 1'b1;
          rd_wait      = $urandom_range(0, lat_max);
          rd_addr_hold = bus.read_addr;
          rd_cnt++;
        end else begin
          wr_out                = 1'b1;
          wr_wait               = $urandom_range(0, lat_max);
          mem[bus.write_addr]   = bus.write_data;
          wr_cnt++;
        end
      end else if (spur_en && !was_busy && !responded && $urandom_range(0, 3) == 0) begin
        bus.read_data_valid = 1'b1;
        bus.read_data       = $urandom;
        bus.write_done      = $urandom_range(0, 1) == 1;
      end
    end
  end

  task automatic run_op(input logic [31:0] ab, input logic [31:0] bb, input logic [31:0] ra,
                        input int len, input logic [63:0] exp, input bit hammer);
    int cyc;
    for (int i = 0; i < len; i++) begin
      mem[ab + 32'(4 * i)] = va[i];
      mem[bb + 32'(4 * i)] = vb[i];
    end
    mem[ra]         = 32'hDEADBEEF;
    mem[ra + 32'd4] = 32'hDEADBEEF;
    rd_cnt   = 0;
    wr_cnt   = 0;
    done_cnt = 0;
    @(negedge clk);
    a_base   = ab;
    b_base   = bb;
    res_addr = ra;
    vec_len  = 16'(len);
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_rise", 64'(busy), 64'd1);
    cyc = 0;
    while (!done && cyc < 5000) begin
      if (hammer && busy && $urandom_range(0, 5) == 0) begin
        start    = 1'b1;
        a_base   = $urandom;
        b_base   = $urandom;
        res_addr = $urandom;
        vec_len  = 16'($urandom_range(0, 9));
      end else start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("done_seen", 64'(done), 64'd1);
    check("busy_at_done", 64'(busy), 64'd0);
    check("result", result, exp);
    check("mem_lo", 64'(mem_rd(ra)), 64'(exp[31:0]));
    check("mem_hi", 64'(mem_rd(ra + 32'd4)), 64'(exp[63:32]));
    check("read_count", 64'(rd_cnt), 64'(2 * len));
    check("write_count", 64'(wr_cnt), 64'd2);
    @(negedge clk);
    check("done_pulse", 64'(done), 64'd0);
    check("done_count", 64'(done_cnt), 64'd1);
    $display("[TB] op len=%0d result=0x%016h expected=0x%016h", len, result, exp);
  endtask

  initial begin
    int cyc;
    int n;
    clk      = 1'b0;
    reset    = 1'b1;
    start    = 1'b0;
    a_base   = '0;
    b_base   = '0;
    res_addr = '0;
    vec_len  = '0;
    bus.read_data       = '0;
    bus.read_data_valid = 1'b0;
    bus.write_done      = 1'b0;
    lat_max  = 0;
    spur_en  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_read_req", 64'(bus.read_req), 64'd0);
    check("rst_write_req", 64'(bus.write_req), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    va = '{32'd1, 32'd2, 32'd3, 32'd4};
    vb = '{32'd5, 32'd6, 32'd7, 32'd8};
    run_op(32'h1000, 32'h2000, 32'h3000, 4, 64'd70, 1'b0);

    va = '{32'hFFFFFFFD};
    vb = '{32'd7};
    run_op(32'h1100, 32'h2100, 32'h3100, 1, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0);

    run_op(32'h1200, 32'h2200, 32'h3200, 0, 64'd0, 1'b0);

    va = '{32'h80000000, 32'h80000000, 32'h80000000};
    vb = '{32'h80000000, 32'h80000000, 32'h80000000};
    run_op(32'h1300, 32'h2300, 32'h3300, 3, 64'hC000_0000_0000_0000, 1'b0);

    lat_max = 20;
    spur_en = 1'b1;
    for (int r = 0; r < 5; r++) begin
      n = $urandom_range(1, 6);
      va.delete();
      vb.delete();
      for (int i = 0; i < n; i++) begin
        va.push_back($urandom);
        vb.push_back($urandom);
      end
      run_op(32'h4000 + 32'(r * 256), 32'h8000 + 32'(r * 256), 32'hC000 + 32'(r * 16),
             n, model_dot(n), 1'b1);
    end

    // Abort a run while the B-operand read is outstanding.
    lat_max = 0;
    spur_en = 1'b0;
    va = '{32'd9, 32'd9, 32'd9, 32'd9};
    vb = '{32'd9, 32'd9, 32'd9, 32'd9};
    for (int i = 0; i < 4; i++) begin
      mem[32'h5000 + 32'(4 * i)] = va[i];
      mem[32'h6000 + 32'(4 * i)] = vb[i];
    end
    rd_cnt = 0;
    @(negedge clk);
    a_base   = 32'h5000;
    b_base   = 32'h6000;
    res_addr = 32'h7000;
    vec_len  = 16'd4;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (rd_cnt < 2 && cyc < 200) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    check("reach_wait_b", 64'(rd_cnt), 64'd2);
    reset = 1'b1;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_result", result, 64'd0);
    check("arst_read_req", 64'(bus.read_req), 64'd0);
    check("arst_read_addr", 64'(bus.read_addr), 64'd0);
    check("arst_write_req", 64'(bus.write_req), 64'd0);
    check("arst_write_addr", 64'(bus.write_addr), 64'd0);
    check("arst_write_data", 64'(bus.write_data), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    va = '{32'd2, 32'hFFFFFFFF, 32'd10, 32'd0};
    vb = '{32'd3, 32'd4, 32'hFFFFFFFE, 32'd5};
    run_op(32'h5400, 32'h6400, 32'h7400, 4, model_dot(4), 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3000000;
    $display("[TB] FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dot_product_engine.md
Name: dot_product_engine

Overview:
- Upstream command stage for `axi_adapter`: computes the signed dot product of two 32-bit-word vectors held in AXI-addressed memory.
- Issues single-word read and write requests on the adapter's request/response interface.
- Accumulates A[i]*B[i] into a 64-bit accumulator, then writes the result back as two words.
- Controlled by a start/busy/done interface from the accelerator register file.

Parameters:
- LEN_W, 16, width of the vector-length operand (max 2^LEN_W-1 elements).
- ACC_W, 64, accumulator width; fixed at 64 (two result words); other values unsupported.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; sampled only in IDLE.
- a_base  in  32  byte address of A[0]; captured on start.
- b_base  in  32  byte address of B[0]; captured on start.
- res_addr  in  32  byte address of result low word; high word at res_addr+4; captured on start.
- vec_len  in  LEN_W  element count; captured on start.
- busy  out  1  high from the cycle after accepted start until done.
- done  out  1  one-cycle pulse after the high result word's write_done.
- result  out  64  final accumulator, valid from done until next accepted start.
- read_req  out  1  to adapter; single-cycle pulse.
- read_addr  out  32  to adapter; held stable from the read_req cycle through read_data_valid.
- read_data  in  32  from adapter; valid only in the cycle read_data_valid=1.
- read_data_valid  in  1  from adapter; one-cycle pulse.
- write_req  out  1  to adapter; single-cycle pulse.
- write_addr  out  32  to adapter.
- write_data  out  32  to adapter.
- write_done  in  1  from adapter; one-cycle pulse.

Behaviour:
- Reset (async, active-high) forces:
  - state=IDLE;
  - busy, done, read_req, write_req = 0;
  - read_addr, write_addr, write_data, result, accumulator, index, pointers, operand regs = 0.
- Reset is honoured mid-operation; any outstanding adapter transaction is abandoned, with no recovery logic.
- All other outputs are registered.
- States and transitions:
  - IDLE: on start, capture operands; pa=a_base, pb=b_base, acc=0, cnt=vec_len. Go to ISSUE_A if vec_len!=0, else WR_LO.
  - ISSUE_A: read_addr=pa, read_req=1 for exactly one cycle, then go to WAIT_A.
  - WAIT_A: on read_data_valid, opa=read_data (captured that cycle) and go to ISSUE_B.
  - ISSUE_B / WAIT_B: same sequence with pb, into opb; then go to MAC.
  - MAC: acc += sext64(opa)*sext64(opb), signed 32x32->64 with 64-bit wraparound and no saturation. pa+=4, pb+=4 (32-bit wrap), cnt-=1. Go to WR_LO if cnt becomes 0, else ISSUE_A.
  - WR_LO: write_addr=res_addr, write_data=acc[31:0], write_req pulse for one cycle, then go to WAIT_LO.
  - WAIT_LO: on write_done, go to WR_HI.
  - WR_HI / WAIT_HI: same sequence with res_addr+4 and acc[63:32]; on write_done, go to FIN.
  - FIN: result=acc, done=1 for one cycle, busy=0, return to IDLE.
- Request rules:
  - read_req and write_req are never high together.
  - Never more than one outstanding request.
  - Requests are pulses because the adapter re-samples a level request in its IDLE state.
- Responses:
  - read_data_valid or write_done outside the matching WAIT state is ignored.
  - Response latency is unbounded; there is no timeout.
- start while busy is ignored: no re-capture, no effect on the in-flight operation.
- start in the same cycle as FIN is ignored; it is accepted only when state==IDLE.
- busy rises the cycle after start is accepted.
- Minimum latency per element with an adapter responding in 1 cycle: 5 cycles (ISSUE_A, WAIT_A, ISSUE_B, WAIT_B, MAC) plus adapter latency.

Decomposition:
- Package dpe_pkg:
  - state enum dpe_state_e;
  - localparams WORD_BYTES=4 and RES_HI_OFS=4.
- Sub-module dpe_mac: registered signed 32x32 multiply plus 64-bit accumulate with clear/enable, isolating DSP inference.
  - If dpe_mac is registered, MAC becomes two cycles (MUL, ACC); the FSM handles this by adding a MUL state.

Test Plan:
- Memory-model adapter stub with 1-cycle response; len=4, A={1,2,3,4}, B={5,6,7,8} -> writes 70 to res_addr and 0 to res_addr+4; result=70; one done pulse.
- len=1, A={0xFFFFFFFD}, B={7} -> low word 0xFFFFFFEB, high word 0xFFFFFFFF; result=-21.
- len=0 -> no read_req at all; writes 0 to res_addr and res_addr+4; done after two write_done responses.
- len=3, all elements 0x80000000 -> result 0xC000000000000000, checks 64-bit wrap (3*2^62).
- Random 0-20 cycle stub latency plus start pulses while busy plus spurious read_data_valid in ISSUE states -> result unchanged vs. golden model. Checker asserts: no concurrent read_req/write_req, ≤1 outstanding request, read_addr stable while waiting.
- Assert reset during WAIT_B of a len=4 run -> all outputs 0 immediately (async). A fresh start then completes correctly with acc starting from 0.
